// File: rtl/pwm_multi_if.sv
// Configuration and status bundle between the register bank and the multi-channel PWM.
interface pwm_multi_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 2
);
  logic                   ena;
  logic                   center;
  logic [WIDTH-1:0]       period;
  logic [NCH*WIDTH-1:0]   duty;
  logic                   update;
  logic [NCH-1:0]         pwm_out;
  logic                   period_start;
  logic                   upd_pending;
  logic                   upd_done;

  modport master (
    output ena, center, period, duty, update,
    input  pwm_out, period_start, upd_pending, upd_done
  );

  modport slave (
    input  ena, center, period, duty, update,
    output pwm_out, period_start, upd_pending, upd_done
  );
endinterface

// File: rtl/pwm_multi.sv
// N-channel PWM on a shared edge/center-aligned time base with shadowed
// period/duty/mode registers that only change at period boundaries.
module pwm_multi #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 2
) (
  input  logic       clk,
  input  logic       resetb,
  pwm_multi_if.slave bus
);

  localparam int unsigned DW = NCH * WIDTH;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_nxt;
  dir_e             dir_q, dir_d, dir_nxt;
  logic [WIDTH-1:0] p_s_q, p_s_d;
  logic [DW-1:0]    d_s_q, d_s_d;
  logic             c_s_q, c_s_d;
  logic             pend_q, pend_d;
  logic             done_q, done_d;
  logic             ps_q, ps_d;
  logic [NCH-1:0]   pwm_q, pwm_d;
  logic             wrap_c;

  // Free-running time base step; wrap_c marks the edge that returns cnt to 0.
  always_comb begin
    cnt_nxt = cnt_q + WIDTH'(1);
    dir_nxt = dir_q;
    wrap_c  = 1'b0;
    if (!c_s_q || (p_s_q == '0)) begin
      if (cnt_q >= p_s_q) begin
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
        wrap_c  = 1'b1;
      end
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= p_s_q) begin
        if (p_s_q == WIDTH'(1)) begin
          cnt_nxt = '0;
          dir_nxt = DIR_UP;
          wrap_c  = 1'b1;
        end else begin
          cnt_nxt = p_s_q - WIDTH'(1);
          dir_nxt = DIR_DOWN;
        end
      end
    end else begin
      if (cnt_q <= WIDTH'(1)) begin
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
        wrap_c  = 1'b1;
      end else begin
        cnt_nxt = cnt_q - WIDTH'(1);
      end
    end
  end

  // Next state: idle keeps shadows transparent, running loads only at a wrap.
  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    p_s_d  = p_s_q;
    d_s_d  = d_s_q;
    c_s_d  = c_s_q;
    pend_d = pend_q;
    done_d = 1'b0;
    ps_d   = bus.ena && (cnt_q == '0);
    for (int i = 0; i < NCH; i++) begin
      pwm_d[i] = bus.ena && (cnt_q < d_s_q[i*WIDTH +: WIDTH]);
    end

    if (!bus.ena) begin
      cnt_d  = '0;
      dir_d  = DIR_UP;
      p_s_d  = bus.period;
      d_s_d  = bus.duty;
      c_s_d  = bus.center;
      pend_d = 1'b0;
    end else begin
      cnt_d = cnt_nxt;
      dir_d = dir_nxt;
      if (wrap_c && (pend_q || bus.update)) begin
        p_s_d  = bus.period;
        d_s_d  = bus.duty;
        c_s_d  = bus.center;
        dir_d  = DIR_UP;
        pend_d = 1'b0;
        done_d = 1'b1;
      end else if (bus.update) begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      p_s_q  <= '0;
      d_s_q  <= '0;
      c_s_q  <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      ps_q   <= 1'b0;
      pwm_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      p_s_q  <= p_s_d;
      d_s_q  <= d_s_d;
      c_s_q  <= c_s_d;
      pend_q <= pend_d;
      done_q <= done_d;
      ps_q   <= ps_d;
      pwm_q  <= pwm_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = ps_q;
  assign bus.upd_pending  = pend_q;
  assign bus.upd_done     = done_q;

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator: the parametrised successor of the single-channel 8-bit duty-cycle PWM driven from the register bank. It adds configurable counter width, N channels sharing one time base, a programmable period, edge- or center-aligned mode and glitch-free shadow-register updates at period boundaries. It sits beside the register bank, which drives its configuration inputs; `pwm_out` goes to pads.

## Interface
- `WIDTH`, 8: counter, period and duty width in bits (≥2).
- `NCH`, 2: number of PWM channels (≥1).

- `clk` in 1: system clock.
- `resetb` in 1: asynchronous active-low reset.
- `ena` in 1: run enable; low holds the time base idle.
- `center` in 1: mode select; 0 = edge-aligned, 1 = center-aligned.
- `period` in WIDTH: period value P.
- `duty` in NCH*WIDTH: channel i duty D[i] = `duty[i*WIDTH +: WIDTH]`.
- `update` in 1: one-cycle request to load `period`/`duty`/`center` into the shadow registers.
- `pwm_out` out NCH: registered PWM outputs.
- `period_start` out 1: one-cycle pulse marking the first cycle of each period.
- `upd_pending` out 1: an update is requested but not yet loaded.
- `upd_done` out 1: one-cycle pulse in the cycle after a requested load.

## Operation
- **State.** Counter `cnt` (WIDTH bits), direction `dir` (0 = up), shadows `P_s`, `D_s[i]`, `C_s`, a pending flag, and the registered outputs.
- **Edge mode (`C_s`=0).** `cnt` runs 0,1,…,P_s then returns to 0. Period = P_s+1 cycles. `dir` stays 0.
- **Center mode (`C_s`=1).** `cnt` runs 0,1,…,P_s,P_s−1,…,1 then returns to 0. Period = 2·P_s cycles.
  - Transitions: up and `cnt`==P_s → `cnt`=P_s−1, `dir`=1.
  - Down and `cnt`==1 → `cnt`=0, `dir`=0.
  - P_s=1 gives the sequence 0,1,0,1…
- **P_s=0, either mode.** `cnt` stays at 0; every cycle is a boundary.
- **Boundary edge.** The clock edge at which next `cnt`=0 and the new period begins; also every cycle while `ena`=0.
- **Compare.** Channel i is high when `ena` is high and `cnt` < D_s[i] (unsigned, WIDTH bits).
  - D_s=0 gives always low.
  - Edge mode with D_s > P_s gives always high.
  - Center mode: the high pulse is centered on `cnt`=0 and lasts 2·D_s−1 cycles for 1 ≤ D_s ≤ P_s, and is constant high for D_s > P_s.
- **Update.**
  - `update`=1 sets pending.
  - At a boundary edge, if pending or `update` is high, load `P_s` ← `period`, `D_s` ← `duty`, `C_s` ← `center`, force `dir`=0, and clear pending.
  - `update` coinciding with a boundary edge loads immediately; pending never sets.
  - Mid-period input changes without `update` are ignored.
- **Idle (`ena`=0).** `cnt`=0, `dir`=0, `pwm_out`=0 and `period_start`=0. Shadows load every cycle (transparent) and pending is cleared.
- **Restart.** When `ena` rises, the first period starts with `cnt`=0 and the shadows hold the values loaded at the last idle cycle.

## Timing
- **Reset values** (async on `resetb` low): `cnt`=0, `dir`=0, shadows=0, pending=0, `pwm_out`=0, `period_start`=0, `upd_pending`=0, `upd_done`=0.
- **Output latency.** `pwm_out` and `period_start` are registered from `cnt` with 1-cycle latency. `period_start`=1 in the cycle after `cnt`=0 begins a period, i.e. aligned with the first output cycle of that period.
- **Update latency.**
  - The new duty is visible on `pwm_out` 1 cycle after the boundary edge that loaded it.
  - Worst case from `update` to a visible change: one full period + 1 cycle.
- **Status outputs.**
  - `upd_pending` rises the cycle after `update` (unless loaded at that same edge) and falls the cycle after the load.
  - `upd_done` pulses for 1 cycle after every load triggered by pending or `update` while `ena`=1. It does not pulse for idle transparent loads.
- **Reset mid-operation.** Reset aborts the period immediately. After `resetb` release, operation restarts from reset values, so `period`/`duty` must be reloaded via `update` or an idle cycle.
- **`ena` mid-period.** Falling `ena` forces `pwm_out`=0 on the following cycle. No partial-period completion.

## Test plan
- **Edge-mode duty.** WIDTH=8, `center`=0, P=9, D0=3, D1=0, idle load, then `ena`=1 → `pwm_out[0]` 3 high/7 low repeating every 10 cycles; `pwm_out[1]` constant 0; `period_start` every 10 cycles aligned with the rising edge of `pwm_out[0]`.
- **Edge-mode saturation.** P=9, D0=10 → `pwm_out[0]` constant 1. P=0, D0=1 → constant 1. P=0, D0=0 → constant 0.
- **Center mode.** P=4, D0=2 → period 8; `pwm_out[0]` high 3 cycles around `cnt`=0 and low 5; D0=4 → high 7 / low 1. P=1, D0=1 → 1 high / 1 low.
- **Buffered update.**
  - Running P=9, D0=3; set D0=7 with an `update` pulse at `cnt`=4.
  - The current period completes with 3 high; `upd_pending`=1 until the boundary; the next period has 7 high; `upd_done` pulses once.
  - Repeat with `update` exactly on the boundary edge → `upd_pending` never rises.
- **Mode switch.** Running center P=4; `update` with `center`=0, P=4 → the switch occurs only at `cnt`=0; afterwards the period is 5 cycles and there are no runt pulses.
- **Reset/`ena` abort.**
  - Assert `resetb`=0 mid-high pulse → `pwm_out`=0 asynchronously and all status outputs 0.
  - Drop `ena` mid-period → `pwm_out`=0 next cycle; on re-enable the first `period_start` occurs 1 cycle after `ena` rises.
